// File: rtl/rvfi_retire_serializer.sv
// -----------------------------------------------------------------------------
// rvfi_retire_serializer
//
// This block takes the records retired on an NRET-wide RVFI bus and re-emits
// them one per cycle as a single-channel stream. Records leave in arrival
// order, and records that arrive in the same cycle leave in channel-index
// order. The output feeds a single-channel instruction checker. The block
// also raises that checker's check strobe when the emitted record's order
// number equals check_order.
//
// Optional feature:
//   RISCV_FORMAL_SERIAL_ORDER_CHECK_EN - when this macro is defined, the block
//     tracks the expected next order number and sets the sticky order_err flag
//     on a gap. When it is undefined, order_err is tied to 0.
//
// Parameters:
//   NRET  - number of input retire channels (1..4). Defaults to
//           RISCV_FORMAL_NRET.
//   RECW  - packed record width. Bits [63:0] hold rvfi_order.
//   DEPTH - number of FIFO entries, not counting the output register. Must be
//           a power of two and >= NRET.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high
//   in_valid    in   [NRET]       per-channel retire valid
//   in_rec      in   [NRET*RECW]  channel c occupies [c*RECW +: RECW]
//   check_order in   [64]         order number that raises out_check
//   out_valid   out  record present on out_rec this cycle
//   out_rec     out  [RECW]       emitted record; holds when idle
//   out_check   out  out_valid and out_rec order == check_order
//   overflow    out  sticky; at least one record was dropped
//   level       out  [clog2(DEPTH+1)] FIFO occupancy
//   order_err   out  sticky order-gap flag
// -----------------------------------------------------------------------------
`ifndef RISCV_FORMAL_NRET
`define RISCV_FORMAL_NRET 1
`endif

module rvfi_retire_serializer #(
  parameter int NRET  = `RISCV_FORMAL_NRET,
  parameter int RECW  = 256,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NRET-1:0]              in_valid,
  input  logic [NRET*RECW-1:0]         in_rec,
  input  logic [63:0]                  check_order,
  output logic                         out_valid,
  output logic [RECW-1:0]              out_rec,
  output logic                         out_check,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         order_err
);

  localparam int LVLW = $clog2(DEPTH+1);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Counts wide enough to hold level + NRET without wrapping
  localparam int CW   = $clog2(DEPTH + NRET + 1) + 1;
  localparam logic [PTRW-1:0] PMASK = PTRW'(DEPTH - 1);

  // Occupancy clamps at DEPTH; anything beyond it has been dropped
  function automatic logic [LVLW-1:0] sat_level(input logic [CW-1:0] s);
    if (s > CW'(DEPTH)) return LVLW'(DEPTH);
    else                return s[LVLW-1:0];
  endfunction

  function automatic logic over_depth(input logic [CW-1:0] s);
    return s > CW'(DEPTH);
  endfunction

  // Storage and control state
  logic [RECW-1:0] r_mem [1 << PTRW];
  logic [PTRW-1:0] r_rptr;
  logic [PTRW-1:0] r_wptr;
  logic [LVLW-1:0] r_level;
  logic            r_overflow;
  logic            r_out_vld_p1;
  logic [RECW-1:0] r_out_rec_p1;
  logic            r_out_check_p1;

  // Combinational next-state signals
  logic [CW-1:0]   w_rank [NRET];
  logic [CW-1:0]   w_npush;
  logic [RECW-1:0] w_first;
  logic [RECW-1:0] w_src [NRET];
  logic            w_pop_fifo;
  logic            w_pop;
  logic            w_skip;
  logic [RECW-1:0] w_pop_rec;
  logic [CW-1:0]   w_sum;
  logic            w_ovf;
  logic [LVLW-1:0] w_level_nxt;
  logic [CW-1:0]   w_nwr;

  // ---- Stage 0: compaction of valid channels, pop select, FIFO write ----

  // The rank of a channel is its position among this cycle's valid channels.
  // The rank removes gaps between valid channels without any variable-index
  // writes.
  always_comb begin
    logic [CW-1:0] acc;
    acc = '0;
    for (int c = 0; c < NRET; c++) begin
      w_rank[c] = acc;
      if (in_valid[c]) acc = acc + CW'(1);
    end
    w_npush = acc;
  end

  // When the FIFO is empty, the lowest-ranked incoming record bypasses
  // straight to the output. The remaining records shift down by one slot
  // before they are stored (w_skip).
  assign w_pop_fifo = (r_level != '0);
  assign w_pop      = w_pop_fifo || (w_npush != '0);
  assign w_skip     = !w_pop_fifo;

  always_comb begin
    w_first = '0;
    for (int k = 0; k < NRET; k++) w_src[k] = '0;
    for (int c = 0; c < NRET; c++) begin
      if (in_valid[c] && (w_rank[c] == '0)) w_first = in_rec[c*RECW +: RECW];
      for (int k = 0; k < NRET; k++) begin
        if (in_valid[c] && (w_rank[c] == (CW'(k) + CW'(w_skip))))
          w_src[k] = in_rec[c*RECW +: RECW];
      end
    end
  end

  assign w_pop_rec   = w_pop_fifo ? r_mem[r_rptr] : w_first;
  assign w_sum       = CW'(r_level) + w_npush - CW'(w_pop);
  assign w_ovf       = over_depth(w_sum);
  assign w_level_nxt = sat_level(w_sum);
  // w_nwr counts the records actually stored. A pop from the FIFO frees one
  // slot. Clamping level to DEPTH drops the excess records, which are the
  // highest-ranked ones because writes fill w_src from index 0 upward.
  assign w_nwr       = CW'(w_level_nxt) - CW'(r_level) + CW'(w_pop_fifo);

  // At full with a pop, wptr equals rptr. Writing that slot is safe: the pop
  // reads the old contents combinationally, before this edge.
  always_ff @(posedge clock) begin
    for (int k = 0; k < NRET; k++) begin
      if (CW'(k) < w_nwr) r_mem[(r_wptr + PTRW'(k)) & PMASK] <= w_src[k];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_wptr  <= (r_wptr + w_nwr[PTRW-1:0]) & PMASK;
      if (w_pop_fifo) r_rptr <= (r_rptr + PTRW'(1)) & PMASK;
      if (w_ovf)      r_overflow <= 1'b1;
    end
  end

  // ---- Stage 1: output register ----
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_vld_p1   <= 1'b0;
      r_out_check_p1 <= 1'b0;
      r_out_rec_p1   <= '0;
    end else begin
      r_out_vld_p1   <= w_pop;
      r_out_check_p1 <= w_pop && (w_pop_rec[63:0] == check_order);
      if (w_pop) r_out_rec_p1 <= w_pop_rec;
    end
  end

  assign out_valid = r_out_vld_p1;
  assign out_rec   = r_out_rec_p1;
  assign out_check = r_out_check_p1;
  assign overflow  = r_overflow;
  assign level     = r_level;

`ifdef RISCV_FORMAL_SERIAL_ORDER_CHECK_EN
  // ---- Stage 2: order-continuity monitor on the emitted stream ----
  logic [63:0] r_exp_order;
  logic        r_exp_init;
  logic        r_order_err;

  // The first record after reset only seeds the expected order
  always_ff @(posedge clock) begin
    if (reset) begin
      r_exp_order <= '0;
      r_exp_init  <= 1'b0;
      r_order_err <= 1'b0;
    end else if (r_out_vld_p1) begin
      if (r_exp_init && (r_out_rec_p1[63:0] != r_exp_order)) r_order_err <= 1'b1;
      r_exp_order <= r_out_rec_p1[63:0] + 64'd1;
      r_exp_init  <= 1'b1;
    end
  end

  assign order_err = r_order_err;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
module tb_rvfi_retire_serializer;

  localparam int NRET  = 2;
  localparam int RECW  = 96;
  localparam int DEPTH = 4;
`ifdef RISCV_FORMAL_SERIAL_ORDER_CHECK_EN
  localparam bit ORDER_CHK = 1'b1;
`else
  localparam bit ORDER_CHK = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NRET-1:0]      in_valid;
  logic [NRET*RECW-1:0] in_rec;
  logic [63:0]          check_order;
  logic                 out_valid;
  logic [RECW-1:0]      out_rec;
  logic                 out_check;
  logic                 overflow;
  logic [2:0]           level;
  logic                 order_err;

  rvfi_retire_serializer #(.NRET(NRET), .RECW(RECW), .DEPTH(DEPTH)) dut (
    .clock(clk), .reset(rst), .in_valid(in_valid), .in_rec(in_rec),
    .check_order(check_order), .out_valid(out_valid), .out_rec(out_rec),
    .out_check(out_check), .overflow(overflow), .level(level),
    .order_err(order_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  vld;
    logic [63:0] o0, o1, chk;
    logic        e_vld;
    logic [63:0] e_ord;
    logic        e_chk;
    logic [2:0]  e_lvl;
    logic        e_ovf;
  } vec_t;

  int total = 0;
  int bad   = 0;

  vec_t            tv[$];
  logic [RECW-1:0] mq[$];     // reference FIFO contents
  logic [RECW-1:0] exp_q[$];  // records expected on the output
  logic [RECW-1:0] last_rec;

  function automatic vec_t v(input logic r, input logic [1:0] vl, input int o0, input int o1,
                             input int chk, input logic ev, input int eo, input logic ec,
                             input int el, input logic eov);
    vec_t t;
    t.rst = r; t.vld = vl; t.o0 = 64'(o0); t.o1 = 64'(o1); t.chk = 64'(chk);
    t.e_vld = ev; t.e_ord = 64'(eo); t.e_chk = ec; t.e_lvl = 3'(el); t.e_ovf = eov;
    return t;
  endfunction

  function automatic logic [RECW-1:0] mkrec(input logic [63:0] o);
    return {o[31:0] ^ 32'hA5A5_5A5A, o};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    logic [RECW-1:0] r;
    rst         = t.rst;
    in_valid    = t.vld;
    in_rec      = {mkrec(t.o1), mkrec(t.o0)};
    check_order = t.chk;
    if (t.rst) begin
      mq.delete();
      exp_q.delete();
      last_rec = '0;
    end else begin
      if (t.vld[0]) mq.push_back(mkrec(t.o0));
      if (t.vld[1]) mq.push_back(mkrec(t.o1));
      if (mq.size() > 0) begin
        r = mq.pop_front();
        exp_q.push_back(r);
        last_rec = r;
      end
      while (mq.size() > DEPTH) void'(mq.pop_back());
    end
    @(posedge clk);
    #1;
    chk($sformatf("out_valid[%0d]", idx), 128'(out_valid), 128'(t.e_vld));
    if (t.e_vld) chk($sformatf("order[%0d]", idx), 128'(out_rec[63:0]), 128'(t.e_ord));
    chk($sformatf("out_check[%0d]", idx), 128'(out_check), 128'(t.e_chk));
    chk($sformatf("level[%0d]", idx), 128'(level), 128'(t.e_lvl));
    chk($sformatf("overflow[%0d]", idx), 128'(overflow), 128'(t.e_ovf));
`ifndef RISCV_FORMAL_SERIAL_ORDER_CHECK_EN
    chk($sformatf("order_err_off[%0d]", idx), 128'(order_err), 128'(0));
`endif
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_unexpected[%0d]: got %0h expected none", idx, out_rec);
      end else begin
        r = exp_q.pop_front();
        chk($sformatf("sb_rec[%0d]", idx), 128'(out_rec), 128'(r));
      end
    end else begin
      chk($sformatf("hold_rec[%0d]", idx), 128'(out_rec), 128'(last_rec));
    end
  endtask

  initial begin
    logic exp_err;
    rst = 1'b1; in_valid = '0; in_rec = '0; check_order = '0; last_rec = '0;

    // rst, vld, o0, o1, chk, e_vld, e_ord, e_chk, e_lvl, e_ovf
    tv.push_back(v(1, 2'b00,  0,  0,  0, 0,  0, 0, 0, 0)); // reset state
    tv.push_back(v(0, 2'b01,  5,  0,  0, 1,  5, 0, 0, 0)); // single channel
    tv.push_back(v(0, 2'b01,  6,  0,  0, 1,  6, 0, 0, 0));
    tv.push_back(v(0, 2'b01,  7,  0,  0, 1,  7, 0, 0, 0));
    tv.push_back(v(0, 2'b00,  0,  0,  0, 0,  0, 0, 0, 0));
    tv.push_back(v(0, 2'b11, 10, 11, 11, 1, 10, 0, 1, 0)); // compaction + check
    tv.push_back(v(0, 2'b00,  0,  0, 11, 1, 11, 1, 0, 0));
    tv.push_back(v(0, 2'b00,  0,  0, 11, 0,  0, 0, 0, 0)); // held 11, no strobe
    tv.push_back(v(0, 2'b11, 30, 31,  0, 1, 30, 0, 1, 0)); // overflow burst
    tv.push_back(v(0, 2'b11, 32, 33,  0, 1, 31, 0, 2, 0));
    tv.push_back(v(0, 2'b11, 34, 35,  0, 1, 32, 0, 3, 0));
    tv.push_back(v(0, 2'b11, 36, 37,  0, 1, 33, 0, 4, 0));
    tv.push_back(v(0, 2'b11, 38, 39,  0, 1, 34, 0, 4, 1)); // 39 dropped
    tv.push_back(v(0, 2'b00,  0,  0,  0, 1, 35, 0, 3, 1));
    tv.push_back(v(0, 2'b00,  0,  0,  0, 1, 36, 0, 2, 1));
    tv.push_back(v(0, 2'b00,  0,  0,  0, 1, 37, 0, 1, 1));
    tv.push_back(v(0, 2'b00,  0,  0,  0, 1, 38, 0, 0, 1));
    tv.push_back(v(0, 2'b00,  0,  0,  0, 0,  0, 0, 0, 1)); // sticky
    tv.push_back(v(1, 2'b00,  0,  0,  0, 0,  0, 0, 0, 0)); // reset clears overflow
    tv.push_back(v(0, 2'b11, 40, 41,  0, 1, 40, 0, 1, 0)); // fill to 3
    tv.push_back(v(0, 2'b11, 42, 43,  0, 1, 41, 0, 2, 0));
    tv.push_back(v(0, 2'b11, 44, 45,  0, 1, 42, 0, 3, 0));
    tv.push_back(v(1, 2'b11, 46, 47,  0, 0,  0, 0, 0, 0)); // reset mid-drain, inputs ignored
    tv.push_back(v(0, 2'b01, 20,  0, 20, 1, 20, 1, 0, 0)); // bypass + check
    tv.push_back(v(0, 2'b00,  0,  0, 20, 0,  0, 0, 0, 0));
    tv.push_back(v(0, 2'b11, 50, 51,  0, 1, 50, 0, 1, 0)); // full + push/pop
    tv.push_back(v(0, 2'b11, 52, 53,  0, 1, 51, 0, 2, 0));
    tv.push_back(v(0, 2'b11, 54, 55,  0, 1, 52, 0, 3, 0));
    tv.push_back(v(0, 2'b11, 56, 57,  0, 1, 53, 0, 4, 0));
    tv.push_back(v(0, 2'b01, 58,  0,  0, 1, 54, 0, 4, 0)); // full, 1 in 1 out
    tv.push_back(v(0, 2'b10,  0, 59,  0, 1, 55, 0, 4, 0)); // ch1 only at full
    tv.push_back(v(0, 2'b00,  0,  0,  0, 1, 56, 0, 3, 0));
    tv.push_back(v(0, 2'b00,  0,  0,  0, 1, 57, 0, 2, 0));
    tv.push_back(v(0, 2'b00,  0,  0,  0, 1, 58, 0, 1, 0));
    tv.push_back(v(0, 2'b00,  0,  0,  0, 1, 59, 0, 0, 0));
    tv.push_back(v(0, 2'b00,  0,  0,  0, 0,  0, 0, 0, 0));

    for (int i = 0; i < tv.size(); i++) apply(tv[i], i);

    // Order-gap sequence: 1, 2, 4
    exp_err = ORDER_CHK;
    apply(v(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 100);
    chk("order_err_rst", 128'(order_err), 128'(0));
    apply(v(0, 2'b01, 1, 0, 0, 1, 1, 0, 0, 0), 101);
    chk("order_err_1", 128'(order_err), 128'(0));
    apply(v(0, 2'b01, 2, 0, 0, 1, 2, 0, 0, 0), 102);
    chk("order_err_2", 128'(order_err), 128'(0));
    apply(v(0, 2'b01, 4, 0, 0, 1, 4, 0, 0, 0), 103);
    chk("order_err_4shown", 128'(order_err), 128'(0));
    apply(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 104);
    chk("order_err_after4", 128'(order_err), 128'(exp_err));
    apply(v(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0), 105);
    chk("order_err_sticky", 128'(order_err), 128'(exp_err));

    chk("sb_drained", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
